// File: rtl/slice_arith.sv
// Multi-cycle WIDTH-bit add/subtract unit that runs one SLICE-bit carry-chain slice per clock.
// Build option: define SLICE_ARITH_FLAGS_EN to compute the ZERO/OVF flags; otherwise they are tied to 0.
module slice_arith #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SLICE = 2
) (
    input  logic             CLKIN,
    input  logic             RESET,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             SUB,
    input  logic             CIN,
    input  logic             USE_C,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] O,
    output logic             COUT,
    output logic             ZERO,
    output logic             OVF
);

    localparam int unsigned N     = WIDTH / SLICE;
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic             busy_d, done_d, cout_d;
    logic [WIDTH-1:0] o_d;
    logic [SLICE:0]   slice_sum;
    logic [WIDTH-1:0] acc_next;
    logic             last_slice;

`ifdef SLICE_ARITH_FLAGS_EN
    logic zero_q, zero_d;
    logic ovf_q, ovf_d;
    assign ZERO = zero_q;
    assign OVF  = ovf_q;
`else
    assign ZERO = 1'b0;
    assign OVF  = 1'b0;
`endif

    // Operands shift right each step, so the active slice always sits in the low SLICE bits.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        busy_d   = BUSY;
        done_d   = 1'b0;
        o_d      = O;
        cout_d   = COUT;
`ifdef SLICE_ARITH_FLAGS_EN
        zero_d   = zero_q;
        ovf_d    = ovf_q;
`endif
        slice_sum  = {1'b0, a_q[SLICE-1:0]} + {1'b0, b_q[SLICE-1:0]} + {{SLICE{1'b0}}, carry_q};
        acc_next   = (acc_q >> SLICE) | (WIDTH'(slice_sum[SLICE-1:0]) << (WIDTH - SLICE));
        last_slice = (idx_q == IDX_W'(N - 1));

        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    a_d     = A;
                    b_d     = SUB ? ~B : B;
                    carry_d = SUB ^ (USE_C & CIN);
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                a_d     = a_q >> SLICE;
                b_d     = b_q >> SLICE;
                carry_d = slice_sum[SLICE];
                idx_d   = idx_q + IDX_W'(1);
                acc_d   = acc_next;
                if (last_slice) begin
                    // Results land on the edge entering FIN so DONE and O appear together.
                    state_d = ST_FIN;
                    done_d  = 1'b1;
                    o_d     = acc_next;
                    cout_d  = slice_sum[SLICE];
`ifdef SLICE_ARITH_FLAGS_EN
                    zero_d  = (acc_next == '0);
                    ovf_d   = (a_q[SLICE-1] == b_q[SLICE-1]) & (slice_sum[SLICE-1] != a_q[SLICE-1]);
`endif
                end
            end
            ST_FIN: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLKIN) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
            O       <= '0;
            COUT    <= 1'b0;
`ifdef SLICE_ARITH_FLAGS_EN
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            BUSY    <= busy_d;
            DONE    <= done_d;
            O       <= o_d;
            COUT    <= cout_d;
`ifdef SLICE_ARITH_FLAGS_EN
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

endmodule

// File: tb/tb_slice_arith.sv
// Scoreboard bench for slice_arith (WIDTH=8, SLICE=2): timing, handshake, reset and arithmetic.
module tb_slice_arith;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned SLICE = 2;
    localparam int unsigned N     = WIDTH / SLICE;

    typedef struct packed {
        logic [WIDTH-1:0] o;
        logic             cout;
        logic             zero;
        logic             ovf;
    } exp_t;

    logic             CLKIN = 1'b0;
    logic             RESET, START, SUB, CIN, USE_C;
    logic [WIDTH-1:0] A, B;
    logic             BUSY, DONE, COUT, ZERO, OVF;
    logic [WIDTH-1:0] O;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb_q[$];
    logic [WIDTH-1:0] cur_o;

    slice_arith #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
        .CLKIN(CLKIN), .RESET(RESET), .START(START), .A(A), .B(B),
        .SUB(SUB), .CIN(CIN), .USE_C(USE_C), .BUSY(BUSY), .DONE(DONE),
        .O(O), .COUT(COUT), .ZERO(ZERO), .OVF(OVF)
    );

    always #5 CLKIN = ~CLKIN;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic sub, input logic cin, input logic use_c);
        exp_t             e;
        logic [WIDTH-1:0] bp;
        logic [WIDTH:0]   s;
        bp     = sub ? ~b : b;
        s      = {1'b0, a} + {1'b0, bp} + {{WIDTH{1'b0}}, sub ^ (use_c & cin)};
        e.o    = s[WIDTH-1:0];
        e.cout = s[WIDTH];
`ifdef SLICE_ARITH_FLAGS_EN
        e.zero = (s[WIDTH-1:0] == '0);
        e.ovf  = (a[WIDTH-1] == bp[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
`else
        e.zero = 1'b0;
        e.ovf  = 1'b0;
`endif
        return e;
    endfunction

    // Result monitor: every DONE pulse must match the oldest outstanding expectation.
    always @(posedge CLKIN) begin
        exp_t e;
        #1;
        if (DONE === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 32'(DONE), 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("o",    32'(O),    32'(e.o));
                check("cout", 32'(COUT), 32'(e.cout));
                check("zero", 32'(ZERO), 32'(e.zero));
                check("ovf",  32'(OVF),  32'(e.ovf));
            end
        end
    end

    // Called at cycle 1 of an operation; walks cycles 1..N+2 checking BUSY/DONE and O hold.
    task automatic track_op(input logic [WIDTH-1:0] new_o);
        for (int k = 1; k <= int'(N) + 1; k++) begin
            check($sformatf("busy_c%0d", k), 32'(BUSY), 32'd1);
            check($sformatf("done_c%0d", k), 32'(DONE), (k == int'(N) + 1) ? 32'd1 : 32'd0);
            if (k <= int'(N)) check($sformatf("o_hold_c%0d", k), 32'(O), 32'(cur_o));
            @(posedge CLKIN); #1;
        end
        cur_o = new_o;
        check("busy_idle", 32'(BUSY), 32'd0);
        check("done_idle", 32'(DONE), 32'd0);
    endtask

    // Called #1 after an edge in an IDLE cycle; returns #1 after an edge in the next IDLE cycle.
    task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic sub, input logic cin, input logic use_c);
        exp_t e;
        A = a; B = b; SUB = sub; CIN = cin; USE_C = use_c; START = 1'b1;
        e = model(a, b, sub, cin, use_c);
        @(posedge CLKIN); #1;
        START = 1'b0;
        sb_q.push_back(e);
        track_op(e.o);
    endtask

    initial begin
        exp_t e1, e2;
        RESET = 1'b1; START = 1'b0; A = '0; B = '0; SUB = 1'b0; CIN = 1'b0; USE_C = 1'b0;
        cur_o = '0;
        repeat (2) @(posedge CLKIN);
        #1;
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_done", 32'(DONE), 32'd0);
        check("rst_o",    32'(O),    32'd0);
        check("rst_cout", 32'(COUT), 32'd0);
        check("rst_zero", 32'(ZERO), 32'd0);
        check("rst_ovf",  32'(OVF),  32'd0);
        RESET = 1'b0;

        do_op(8'h5A, 8'h33, 1'b0, 1'b0, 1'b0);
        check("add_o_direct", 32'(O), 32'h8D);
        do_op(8'h10, 8'h01, 1'b1, 1'b0, 1'b0);
        check("sub_o_direct", 32'(O), 32'h0F);
        do_op(8'h00, 8'h01, 1'b1, 1'b0, 1'b0);
        check("borrow_cout_direct", 32'(COUT), 32'd0);
        do_op(8'hFF, 8'h00, 1'b0, 1'b1, 1'b1);
        check("chain_cout_direct", 32'(COUT), 32'd1);
        do_op(8'h7F, 8'h01, 1'b0, 1'b0, 1'b0);
        check("ovf_o_direct", 32'(O), 32'h80);
        do_op(8'h7F, 8'h01, 1'b1, 1'b1, 1'b1);
        do_op(8'h80, 8'h01, 1'b1, 1'b0, 1'b1);

        // START held high: second operation accepted only at cycle N+2.
        e1 = model(8'hC3, 8'h5C, 1'b0, 1'b1, 1'b1);
        e2 = model(8'h21, 8'h42, 1'b1, 1'b0, 1'b0);
        A = 8'hC3; B = 8'h5C; SUB = 1'b0; CIN = 1'b1; USE_C = 1'b1; START = 1'b1;
        @(posedge CLKIN); #1;
        sb_q.push_back(e1);
        A = 8'h21; B = 8'h42; SUB = 1'b1; CIN = 1'b0; USE_C = 1'b0;
        track_op(e1.o);
        sb_q.push_back(e2);
        @(posedge CLKIN); #1;
        START = 1'b0;
        track_op(e2.o);

        // START pulses during BUSY are ignored.
        A = 8'h0F; B = 8'hF0; SUB = 1'b0; CIN = 1'b0; USE_C = 1'b0; START = 1'b1;
        e1 = model(8'h0F, 8'hF0, 1'b0, 1'b0, 1'b0);
        @(posedge CLKIN); #1;
        sb_q.push_back(e1);
        START = 1'b0;
        for (int k = 1; k <= int'(N) + 1; k++) begin
            check($sformatf("pulse_busy_c%0d", k), 32'(BUSY), 32'd1);
            check($sformatf("pulse_done_c%0d", k), 32'(DONE), (k == int'(N) + 1) ? 32'd1 : 32'd0);
            if (k <= int'(N)) check($sformatf("pulse_o_hold_c%0d", k), 32'(O), 32'(cur_o));
            START = (k == 2 || k == 4) ? 1'b1 : 1'b0;
            A = 8'hAA; B = 8'h55;
            @(posedge CLKIN); #1;
        end
        START = 1'b0;
        cur_o = e1.o;
        check("pulse_busy_idle", 32'(BUSY), 32'd0);
        @(posedge CLKIN); #1;
        check("pulse_no_restart", 32'(BUSY), 32'd0);

        // Mid-operation reset in RUN cycle 2.
        A = 8'h99; B = 8'h11; SUB = 1'b0; START = 1'b1;
        @(posedge CLKIN); #1;
        START = 1'b0;
        @(posedge CLKIN); #1;
        RESET = 1'b1;
        @(posedge CLKIN); #1;
        check("mrst_busy", 32'(BUSY), 32'd0);
        check("mrst_done", 32'(DONE), 32'd0);
        check("mrst_o",    32'(O),    32'd0);
        check("mrst_cout", 32'(COUT), 32'd0);
        cur_o = '0;
        RESET = 1'b0;
        do_op(8'h44, 8'h45, 1'b1, 1'b0, 1'b0);

        // RESET and START together: START dropped.
        RESET = 1'b1; START = 1'b1;
        @(posedge CLKIN); #1;
        RESET = 1'b0; START = 1'b0;
        check("rs_busy0", 32'(BUSY), 32'd0);
        @(posedge CLKIN); #1;
        check("rs_busy1", 32'(BUSY), 32'd0);
        cur_o = '0;

        for (int i = 0; i < 10; i++) begin
            do_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        end

        repeat (3) @(posedge CLKIN);
        #1;
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
